// File: rtl/spi_master_ctrl_if.sv
// Bus bundle between the SPI master controller and its user/slave side.
// The master modport is the controller view; slave is the requester/slave view.
interface spi_master_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             miso;
  logic             sclk;
  logic             mosi;
  logic             cs_n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;

  modport master (
    input  start, tx_data, miso,
    output sclk, mosi, cs_n, busy, done, rx_data
  );

  modport slave (
    output start, tx_data, miso,
    input  sclk, mosi, cs_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0, MSB-first SPI master: one WIDTH-bit full-duplex frame per accepted START,
// SCLK half-period of CLK_DIV system clocks, all bus outputs registered.
//
// state | meaning
// IDLE  | CS_N high, waiting for START
// SETUP | CS_N low, first bit on MOSI, SCLK low
// HIGH  | SCLK high, MISO captured on entry
// LOW   | SCLK low, next bit presented on entry
// HOLD  | SCLK low after last bit, CS_N still low
module spi_master_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  spi_master_ctrl_if.master bus
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] rx_data_q;

  logic sclk_q, mosi_q, cs_n_q, busy_q, done_q;
  logic sclk_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt;

  logic div_last;
  logic bit_last;
  logic accept;
  logic rise;
  logic fall;
  logic frame_end;

  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_last  = (bit_cnt == BIT_W'(WIDTH - 1));
  assign accept    = (state == IDLE) && bus.start;
  assign rise      = ((state == SETUP) || (state == LOW)) && div_last;
  assign fall      = (state == HIGH) && div_last && !bit_last;
  assign frame_end = (state == HOLD) && div_last;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETUP;
      SETUP:   if (div_last)  state_nxt = HIGH;
      HIGH:    if (div_last)  state_nxt = bit_last ? HOLD : LOW;
      LOW:     if (div_last)  state_nxt = HIGH;
      HOLD:    if (div_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered bus outputs; they change on the same edge as the state.
  always_comb begin
    sclk_nxt = sclk_q;
    mosi_nxt = mosi_q;
    cs_n_nxt = cs_n_q;
    busy_nxt = busy_q;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          cs_n_nxt = 1'b0;
          busy_nxt = 1'b1;
          mosi_nxt = bus.tx_data[WIDTH-1];
        end
      end
      SETUP, LOW: begin
        if (div_last) sclk_nxt = 1'b1;
      end
      HIGH: begin
        if (div_last) begin
          sclk_nxt = 1'b0;
          if (!bit_last) mosi_nxt = tx_sr[WIDTH-2];
        end
      end
      HOLD: begin
        if (div_last) begin
          cs_n_nxt = 1'b1;
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
          mosi_nxt = 1'b0;
        end
      end
      default: begin
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        cs_n_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sclk_q <= sclk_nxt;
      mosi_q <= mosi_nxt;
      cs_n_q <= cs_n_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Divider restarts on every state change so each non-idle state lasts CLK_DIV cycles.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt <= '0;
    end else if (state_nxt != state) begin
      div_cnt <= '0;
    end else if (state != IDLE) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      rx_data_q <= '0;
    end else begin
      if (accept) begin
        tx_sr   <= bus.tx_data;
        bit_cnt <= '0;
      end else if (fall) begin
        tx_sr   <= tx_sr << 1;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (rise) rx_sr <= {rx_sr[WIDTH-2:0], bus.miso};
      if (frame_end) rx_data_q <= rx_sr;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a CLK_DIV=2 instance (loopback, downstream
// shift register, handshake, abort) and a CLK_DIV=1 instance (minimum divider).
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       sel;
  logic       start_req;
  logic [3:0] tx_req;
  logic       loop_en;
  logic       miso_fix;
  logic [3:0] ds_sr = 4'hf;
  logic [3:0] prev_rx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.WIDTH(4)) bus0 ();
  spi_master_ctrl_if #(.WIDTH(4)) bus1 ();

  spi_master_ctrl #(.WIDTH(4), .CLK_DIV(2)) u_dut0 (.clk(clk), .clr_n(clr_n), .bus(bus0.master));
  spi_master_ctrl #(.WIDTH(4), .CLK_DIV(1)) u_dut1 (.clk(clk), .clr_n(clr_n), .bus(bus1.master));

  assign bus0.start   = start_req & ~sel;
  assign bus1.start   = start_req & sel;
  assign bus0.tx_data = tx_req;
  assign bus1.tx_data = tx_req;
  assign bus0.miso    = loop_en ? bus0.mosi : miso_fix;
  assign bus1.miso    = miso_fix;

  // Downstream 4-bit serial-in register clocked by SCLK
  always @(posedge bus0.sclk) ds_sr <= {ds_sr[2:0], bus0.mosi};

  logic       sclk_o, mosi_o, cs_n_o, busy_o, done_o;
  logic [3:0] rx_o;
  always_comb begin
    sclk_o = sel ? bus1.sclk    : bus0.sclk;
    mosi_o = sel ? bus1.mosi    : bus0.mosi;
    cs_n_o = sel ? bus1.cs_n    : bus0.cs_n;
    busy_o = sel ? bus1.busy    : bus0.busy;
    done_o = sel ? bus1.done    : bus0.done;
    rx_o   = sel ? bus1.rx_data : bus0.rx_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [3:0] exp_rx);
    check_eq({tag, " sclk"}, 32'(sclk_o), 32'd0);
    check_eq({tag, " cs_n"}, 32'(cs_n_o), 32'd1);
    check_eq({tag, " mosi"}, 32'(mosi_o), 32'd0);
    check_eq({tag, " busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, " done"}, 32'(done_o), 32'd0);
    check_eq({tag, " rx_data"}, 32'(rx_o), 32'(exp_rx));
  endtask

  // Called #1 after an edge; the next edge is t0.
  task automatic start_frame(input string tag, input logic [3:0] tx);
    tx_req    = tx;
    start_req = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, " t0 cs_n"}, 32'(cs_n_o), 32'd0);
    check_eq({tag, " t0 busy"}, 32'(busy_o), 32'd1);
    check_eq({tag, " t0 mosi"}, 32'(mosi_o), 32'(tx[3]));
  endtask

  // Called #1 after t0. With chain set, START stays high and a new frame
  // carrying tx2 must be accepted on the edge right after the DONE cycle.
  task automatic watch_frame(input string tag, input logic [3:0] tx, input int d,
                             input logic [3:0] exp_rx, input bit chain, input logic [3:0] tx2);
    int rises    = 0;
    int busy_cnt = 1;
    int extra    = 0;
    int cs_hi    = 0;
    int bad_sclk = 0;
    int last;
    logic prev_sclk = 1'b0;
    last = chain ? 9*d + 1 : 9*d + 2;
    if (!chain) start_req = 1'b0;
    tx_req = ~tx;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      if (sclk_o && !prev_sclk) begin
        rises++;
        if (rises <= 4) begin
          check_eq($sformatf("%s rise%0d time", tag, rises), 32'(n), 32'(d*(2*rises-1)));
          check_eq($sformatf("%s rise%0d mosi", tag, rises), 32'(mosi_o), 32'(tx[4-rises]));
        end
      end
      prev_sclk = sclk_o;
      if (sclk_o && cs_n_o) bad_sclk++;
      if (done_o && n != 9*d) extra++;
      if (n < 9*d) begin
        if (busy_o) busy_cnt++;
        if (cs_n_o) cs_hi++;
      end
      if (n == 9*d - 1) check_eq({tag, " rx held"}, 32'(rx_o), 32'(prev_rx));
      if (n == 9*d) begin
        check_eq({tag, " done"}, 32'(done_o), 32'd1);
        check_eq({tag, " end cs_n"}, 32'(cs_n_o), 32'd1);
        check_eq({tag, " end busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, " rx_data"}, 32'(rx_o), 32'(exp_rx));
        prev_rx = exp_rx;
        if (chain) tx_req = tx2;
      end
      if (chain && n == 9*d + 1) begin
        check_eq({tag, " rearm cs_n"}, 32'(cs_n_o), 32'd0);
        check_eq({tag, " rearm mosi"}, 32'(mosi_o), 32'(tx2[3]));
      end
    end
    check_eq({tag, " rises"}, 32'(rises), 32'd4);
    check_eq({tag, " busy cycles"}, 32'(busy_cnt), 32'(9*d));
    check_eq({tag, " extra done"}, 32'(extra), 32'd0);
    check_eq({tag, " cs_n early"}, 32'(cs_hi), 32'd0);
    check_eq({tag, " sclk w/o cs"}, 32'(bad_sclk), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    clr_n     = 1'b0;
    sel       = 1'b0;
    start_req = 1'b0;
    tx_req    = 4'h0;
    loop_en   = 1'b1;
    miso_fix  = 1'b0;
    prev_rx   = 4'h0;
    #12;
    check_idle_outputs("reset dut0", 4'h0);
    sel = 1'b1; #1;
    check_idle_outputs("reset dut1", 4'h0);
    sel = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    @(posedge clk); #1;

    start_frame("loop1011", 4'b1011);
    watch_frame("loop1011", 4'b1011, 2, 4'b1011, 1'b0, 4'h0);

    start_frame("ds0110", 4'b0110);
    watch_frame("ds0110", 4'b0110, 2, 4'b0110, 1'b0, 4'h0);
    check_eq("downstream reg", 32'(ds_sr), 32'(4'b0110));

    start_frame("held1100", 4'b1100);
    watch_frame("held1100", 4'b1100, 2, 4'b1100, 1'b1, 4'b0101);
    watch_frame("chain0101", 4'b0101, 2, 4'b0101, 1'b0, 4'h0);

    start_frame("abort", 4'b0110);
    start_req = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check_idle_outputs("abort", 4'h0);
    prev_rx = 4'h0;
    @(negedge clk); clr_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    check_eq("abort no done", 32'(dones), 32'd0);

    start_frame("recover1001", 4'b1001);
    watch_frame("recover1001", 4'b1001, 2, 4'b1001, 1'b0, 4'h0);

    sel      = 1'b1;
    loop_en  = 1'b0;
    miso_fix = 1'b1;
    prev_rx  = 4'h0;
    @(posedge clk); #1;
    start_frame("div1", 4'b0000);
    watch_frame("div1", 4'b0000, 1, 4'b1111, 1'b0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
